one_byte_uart_tx: RTL and testbench
===================================

Name: one_byte_uart_tx

Overview:
- Single-byte UART transmitter, 8N1, LSB first, idle-high line.
- It is the transmit counterpart of the team's oversampling UART receiver and uses the same CLK_FREQ/BAUD_RATE parameterisation, so a TX→RX loopback works without adjustment.
- It accepts one byte per start pulse, serialises it at the bit period and reports busy and done.
- Sits between a byte producer (CPU/register interface, test pattern gen) and the pad.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bit/s.
- BAUD_CNT (localparam): CLK_FREQ / BAUD_RATE, integer truncated. This is the clock count per bit, 434 at the defaults.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_en  input  1  enables acceptance of new frames.
- tx_start  input  1  request to send, level-sampled in IDLE.
- tx_data  input  8  byte to send, captured on acceptance.
- tx_out  output  1  serial line, registered.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse when a frame completes.
- tx_current_state  output  2  FSM state, for debug.

Behaviour:
- Reset values: tx_out=1, tx_busy=0, tx_done=0, tx_current_state=IDLE. The shift register and counters clear to 0.
- FSM encoding: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11.
- Acceptance occurs at edge k when state=IDLE and tx_en=1 and tx_start=1. At that edge:
  - tx_data is latched into the shift register;
  - state→START, tx_out←0, tx_busy←1;
  - baud counter←0, bit counter←0.
- Baud counter:
  - runs 0..BAUD_CNT-1 while not IDLE and wraps to 0;
  - bit_tick is asserted when the counter equals BAUD_CNT-1;
  - it is held at 0 in IDLE.
- START: on bit_tick, go to DATA and drive tx_out←shift[0].
- DATA:
  - on each bit_tick, shift right and increment the bit counter (0..7);
  - bit i is driven from edge k+(i+1)*BAUD_CNT;
  - after bit 7's tick, go to STOP and drive tx_out←1.
- STOP: on bit_tick (edge k+10*BAUD_CNT), go to IDLE, tx_busy←0, tx_done←1 for exactly one cycle.
- Every bit lasts exactly BAUD_CNT cycles. The frame runs from edge k to edge k+10*BAUD_CNT.
- Back-to-back frames: tx_start may be held high. The next acceptance is at the edge ending the tx_done cycle, so the line stays high for BAUD_CNT+1 cycles between frames.
- tx_start while busy is ignored. It is not queued.
- Changes to tx_data after acceptance have no effect on the frame in progress.
- tx_en falling mid-frame: the current frame completes normally, and no new frame is accepted.
- Reset mid-frame: tx_out goes high immediately, and all state returns to reset values. The partial frame is abandoned; the receiver sees a framing break.
- tx_done and tx_busy are never both 1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - an EVEN parity bit (XOR of tx_data) is inserted between bit 7 and the stop bit;
  - a PARITY state is added, so the encoding widens to 3 bits and tx_current_state becomes 3 bits wide;
  - the frame lasts 11*BAUD_CNT.
- Undefined: 8N1 exactly as above, with no parity logic synthesised.

Decomposition:
- Package uart_pkg holds:
  - state localparams (IDLE/START/DATA/STOP, plus PARITY);
  - DATA_BITS=8;
  - a baud-divisor function (CLK_FREQ/BAUD_RATE), which the receiver may later share.
- One natural sub-module: uart_baud_gen.
  - Parameters: CLK_FREQ and BAUD_RATE.
  - Inputs: clk, rst_n, and an enable/clear input.
  - Output: bit_tick.
  - Reusable by the receiver's sample-tick logic when its divisor is a parameter.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so BAUD_CNT=10):
- Single byte: tx_en=1, one-cycle tx_start with tx_data=8'hA5.
  - tx_out sequence, 10 cycles each: 0,1,0,1,0,0,1,0,1,1.
  - tx_busy stays high for 100 cycles, then tx_done pulses for 1 cycle.
- Held start: tx_start held high with tx_data 8'h00 then 8'hFF.
  - Two frames are sent, with 11 high cycles between the stop-bit start and the next start bit.
  - tx_done pulses twice.
- Ignore while busy: pulse tx_start with 8'h3C at cycle 35 of an 8'h55 frame.
  - Only 8'h55 is transmitted; one tx_done.
  - tx_data changing mid-frame does not alter the bits.
- Disabled: tx_en=0, tx_start=1 for 200 cycles.
  - tx_out stays 1, tx_busy=0, no tx_done.
  - Dropping tx_en mid-frame still completes that frame.
- Reset mid-frame: assert rst_n=0 during bit 3 of 8'h81.
  - tx_out=1 asynchronously, state=IDLE, no tx_done.
  - After release, a new 8'h81 frame transmits correctly.
- Loopback and parity:
  - tx_out wired to the UART receiver (same parameters) for 8'h00, 8'hFF and 8'h5A: rx_data matches each byte and rx_done fires once per frame.
  - With UART_TX_PARITY_EN, 8'h07 gives parity bit 1 and an 110-cycle frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART states, data width and baud divisor.
// Defining UART_TX_PARITY_EN adds the PARITY state and widens the state encoding to 3 bits.
package uart_pkg;
  localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    STOP   = 3'b011,
    PARITY = 3'b100
  } state_t;
`else
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;
`endif
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, held at 0 while en is low, ticking on its last count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_tick
);
  localparam int BAUD_CNT = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CW = BAUD_CNT > 1 ? $clog2(BAUD_CNT) : 1;
  logic [CW-1:0] cnt;
  assign bit_tick = en && (cnt == CW'(BAUD_CNT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/one_byte_uart_tx.sv
// one_byte_uart_tx: single-byte 8N1 UART transmitter, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module one_byte_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_en,
  input  logic               tx_start,
  input  logic [7:0]         tx_data,
  output logic               tx_out,
  output logic               tx_busy,
  output logic               tx_done,
  output logic [STATE_W-1:0] tx_current_state
);
  localparam int BW = $clog2(DATA_BITS);
  state_t state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic out_n, busy_n, done_n, bit_tick;
`ifdef UART_TX_PARITY_EN
  logic par, par_n;
`endif
  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .en(state != IDLE),
    .bit_tick(bit_tick)
  );
  assign tx_current_state = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_n;
      tx_out  <= out_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
`ifdef UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_cnt;
    out_n   = tx_out;
    busy_n  = tx_busy;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: if (tx_en && tx_start) begin
        state_n = START;
        shift_n = tx_data;
        bit_n   = '0;
        out_n   = 1'b0;
        busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_n   = ^tx_data;
`endif
      end
      START: if (bit_tick) begin
        state_n = DATA;
        out_n   = shift[0];
      end
      // shift[1] is the next bit because the register shifts on this same edge
      DATA: if (bit_tick) begin
        shift_n = shift >> 1;
        bit_n   = bit_cnt + 1'b1;
        if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
          out_n   = par;
`else
          state_n = STOP;
          out_n   = 1'b1;
`endif
        end else out_n = shift[1];
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_tick) begin
        state_n = STOP;
        out_n   = 1'b1;
      end
`endif
      STOP: if (bit_tick) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_one_byte_uart_tx.sv
// tb_one_byte_uart_tx: cycle-exact frame checks plus a mid-bit sampling receiver fed by a byte scoreboard.
module tb_one_byte_uart_tx;
  localparam int B = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam int SW = 3;
`else
  localparam int NB = 10;
  localparam int SW = 2;
`endif
  logic clk = 1'b0, rst_n, tx_en, tx_start;
  logic [7:0] tx_data;
  logic tx_out, tx_busy, tx_done;
  logic [SW-1:0] tx_current_state;
  int checks = 0, errors = 0, done_cnt = 0, overlap = 0, rx_frames = 0, pushed = 0;
  logic rst_seen = 1'b0;
  logic [7:0] q[$];

  one_byte_uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_en(tx_en),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_out(tx_out),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_current_state(tx_current_state)
  );

  always #5 clk = ~clk;
  always @(negedge rst_n) rst_seen = 1'b1;
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_done === 1'b1 && tx_busy === 1'b1) overlap++;
  end

  initial begin : monitor
    logic [7:0] r, e;
    logic ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_out === 1'b0) begin
        rst_seen = 1'b0;
        repeat (B / 2) @(negedge clk);
        ok = (tx_out === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          r[i] = tx_out;
        end
`ifdef UART_TX_PARITY_EN
        repeat (B) @(negedge clk);
        ok = ok && (tx_out === ^r);
`endif
        repeat (B) @(negedge clk);
        ok = ok && (tx_out === 1'b1);
        if (!rst_seen) begin
          rx_frames++;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got byte %h framing_ok=%b, want no frame", r, ok);
          end else begin
            e = q.pop_front();
            if (r !== e || !ok) begin
              errors++;
              $display("FAIL rx_byte: got %h framing_ok=%b, want %h framing_ok=1", r, ok, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [7:0] d, input bit push);
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    if (push) begin
      q.push_back(d);
      pushed++;
    end
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic check_frame(input logic [7:0] d);
    logic [NB-1:0] fb;
`ifdef UART_TX_PARITY_EN
    fb = {1'b1, ^d, d, 1'b0};
`else
    fb = {1'b1, d, 1'b0};
`endif
    for (int j = 0; j < NB * B; j++) begin
      if (j > 0) @(negedge clk);
      checks++;
      if (tx_out !== fb[j / B] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
        errors++;
        $display("FAIL frame_%h cycle %0d: out=%b busy=%b done=%b, want out=%b busy=1 done=0",
                 d, j, tx_out, tx_busy, tx_done, fb[j / B]);
      end
    end
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b1) begin
      errors++;
      $display("FAIL done_%h: out=%b busy=%b done=%b, want out=1 busy=0 done=1", d, tx_out, tx_busy, tx_done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tx_en = 1'b0;
    tx_start = 1'b0;
    tx_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_current_state !== '0) begin
      errors++;
      $display("FAIL reset: out=%b busy=%b done=%b state=%0d, want 1 0 0 0", tx_out, tx_busy, tx_done, tx_current_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_current_state !== '0) begin
      errors++;
      $display("FAIL post_reset: out=%b state=%0d, want 1 0", tx_out, tx_current_state);
    end
  endtask

  task automatic test_single;
    tx_en = 1'b1;
    send(8'hA5, 1'b1);
    check_frame(8'hA5);
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0 || tx_current_state !== '0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL single_after: done=%b state=%0d done_cnt=%0d, want 0 0 1", tx_done, tx_current_state, done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    @(negedge clk);
    tx_data = 8'h00;
    tx_start = 1'b1;
    q.push_back(8'h00);
    pushed++;
    @(negedge clk);
    check_frame(8'h00);
    tx_data = 8'hFF;
    q.push_back(8'hFF);
    pushed++;
    @(negedge clk);
    tx_start = 1'b0;
    check_frame(8'hFF);
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 2 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back: done pulses=%0d busy=%b, want 2 0", done_cnt - d0, tx_busy);
    end
  endtask

  task automatic test_ignore_busy;
    int d0 = done_cnt;
    send(8'h55, 1'b1);
    fork
      check_frame(8'h55);
      begin
        repeat (35) @(negedge clk);
        tx_data = 8'h3C;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || tx_busy !== 1'b0 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: done pulses=%0d busy=%b out=%b, want 1 0 1", done_cnt - d0, tx_busy, tx_out);
    end
  endtask

  task automatic test_disabled;
    int bad = 0, d0 = done_cnt;
    @(negedge clk);
    tx_en = 1'b0;
    tx_start = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL disabled: %0d active cycles, want 0", bad);
    end
    tx_start = 1'b0;
    tx_en = 1'b1;
    send(8'h96, 1'b1);
    fork
      check_frame(8'h96);
      begin
        repeat (40) @(negedge clk);
        tx_en = 1'b0;
        tx_start = 1'b1;
      end
    join
    repeat (30) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || tx_current_state !== '0 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL en_drop: busy=%b state=%0d done pulses=%0d, want 0 0 1", tx_busy, tx_current_state, done_cnt - d0);
    end
    tx_start = 1'b0;
    tx_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    int d0 = done_cnt;
    send(8'h81, 1'b0);
    repeat (43) @(negedge clk);
    checks++;
    if (tx_out !== 1'b0 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_bit3: out=%b busy=%b, want 0 1", tx_out, tx_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_current_state !== '0) begin
      errors++;
      $display("FAIL async_reset: out=%b busy=%b state=%0d, want 1 0 0", tx_out, tx_busy, tx_current_state);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || tx_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_abandon: done pulses=%0d out=%b, want 0 1", done_cnt - d0, tx_out);
    end
    send(8'h81, 1'b1);
    check_frame(8'h81);
  endtask

  task automatic test_loopback;
    logic [7:0] pat[3] = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      send(pat[i], 1'b1);
      check_frame(pat[i]);
    end
`ifdef UART_TX_PARITY_EN
    send(8'h07, 1'b1);
    check_frame(8'h07);
`endif
    repeat (20) @(negedge clk);
    checks++;
    if (rx_frames !== pushed || q.size() !== 0) begin
      errors++;
      $display("FAIL loopback: rx frames=%0d pending=%0d, want %0d 0", rx_frames, q.size(), pushed);
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL busy_done_overlap: %0d cycles, want 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_disabled();
    test_reset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
